// File: rtl/amci_arbiter_pkg.sv
// Shared AMCI field layout and response codes for the arbiter, its interface and any AMCI client.
// The MOSI/MISO offsets are helper functions so that every user derives them from the same AW/DW.
package amci_arbiter_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // MOSI layout, LSB first: waddr, wdata, raddr, write bit, read bit
  function automatic int mosi_wdata_lo(input int aw);
    return aw;
  endfunction

  function automatic int mosi_raddr_lo(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int mosi_write_bit(input int aw, input int dw);
    return 2 * aw + dw;
  endfunction

  function automatic int mosi_read_bit(input int aw, input int dw);
    return 2 * aw + dw + 1;
  endfunction

  function automatic int mosi_width(input int aw, input int dw);
    return 2 * aw + dw + 2;
  endfunction

  // MISO layout, LSB first: rdata, widle, ridle, wresp[2], rresp[2]
  function automatic int miso_widle_bit(input int dw);
    return dw;
  endfunction

  function automatic int miso_ridle_bit(input int dw);
    return dw + 1;
  endfunction

  function automatic int miso_wresp_lo(input int dw);
    return dw + 2;
  endfunction

  function automatic int miso_rresp_lo(input int dw);
    return dw + 4;
  endfunction

  function automatic int miso_width(input int dw);
    return dw + 6;
  endfunction

endpackage

// File: rtl/amci_arbiter_if.sv
// Requester-side command bus plus the shared AMCI port; master = arbiter view, slave = environment view.
interface amci_arbiter_if
  import amci_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]                           REQ_VALID;
  logic [NUM_REQ-1:0]                           REQ_RNW;
  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]            REQ_ADDR;
  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]            REQ_WDATA;
  logic [NUM_REQ-1:0]                           REQ_GRANT;
  logic [NUM_REQ-1:0]                           REQ_DONE;
  logic [AXI_DATA_WIDTH-1:0]                    RSP_RDATA;
  logic [1:0]                                   RSP_RESP;
  logic [mosi_width(AXI_ADDR_WIDTH, AXI_DATA_WIDTH)-1:0] AMCI_MOSI;
  logic [miso_width(AXI_DATA_WIDTH)-1:0]        AMCI_MISO;

  modport master (
    input  REQ_VALID, REQ_RNW, REQ_ADDR, REQ_WDATA, AMCI_MISO,
    output REQ_GRANT, REQ_DONE, RSP_RDATA, RSP_RESP, AMCI_MOSI
  );

  modport slave (
    output REQ_VALID, REQ_RNW, REQ_ADDR, REQ_WDATA, AMCI_MISO,
    input  REQ_GRANT, REQ_DONE, RSP_RDATA, RSP_RESP, AMCI_MOSI
  );

endinterface

// File: rtl/amci_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               found
);

  int k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/amci_arbiter.sv
// Round-robin arbiter serialising single-beat AMCI read/write commands from NUM_REQ requesters.
// One command in flight at a time: IDLE -> ISSUE (one-cycle pulse) -> WAIT (master busy) -> DONE.
module amci_arbiter
  import amci_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic           M_AXI_ACLK,
  input  logic           M_AXI_ARESET,
  amci_arbiter_if.master bus
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int IW = $clog2(NUM_REQ);
  localparam int MW = mosi_width(AW, DW);

  localparam int MOSI_WDATA_LO = mosi_wdata_lo(AW);
  localparam int MOSI_RADDR_LO = mosi_raddr_lo(AW, DW);
  localparam int MOSI_WR_BIT   = mosi_write_bit(AW, DW);
  localparam int MOSI_RD_BIT   = mosi_read_bit(AW, DW);
  localparam int MISO_WIDLE    = miso_widle_bit(DW);
  localparam int MISO_RIDLE    = miso_ridle_bit(DW);
  localparam int MISO_WRESP_LO = miso_wresp_lo(DW);
  localparam int MISO_RRESP_LO = miso_rresp_lo(DW);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic [DW-1:0]      rsp_rdata_q;
  logic [1:0]         rsp_resp_q;

  logic               cmd_rnw;
  logic [AW-1:0]      cmd_addr;
  logic [DW-1:0]      cmd_wdata;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_found;
  logic               widle;
  logic               ridle;
  logic               xfer_idle;
  logic               start;
  logic [MW-1:0]      mosi;

  assign widle     = bus.AMCI_MISO[MISO_WIDLE];
  assign ridle     = bus.AMCI_MISO[MISO_RIDLE];
  assign xfer_idle = cmd_rnw ? ridle : widle;
  // A grant also needs both master channels idle, covering reset skew with the AXI master.
  assign start     = (state == ST_IDLE) && arb_found && widle && ridle;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .req   (bus.REQ_VALID),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      win_idx     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_ISSUE;
            grant_q <= arb_gnt;
            win_idx <= arb_idx;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (xfer_idle) begin
            state      <= ST_DONE;
            done_q     <= grant_q;
            rsp_resp_q <= cmd_rnw ? bus.AMCI_MISO[MISO_RRESP_LO +: 2]
                                  : bus.AMCI_MISO[MISO_WRESP_LO +: 2];
            if (cmd_rnw)
              rsp_rdata_q <= bus.AMCI_MISO[DW-1:0];
            // The winner drops to lowest priority for the next arbitration.
            rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          end
        end
        default: begin
          grant_q <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Command is sampled only at grant; later changes or a dropped REQ_VALID do not affect it.
  always_ff @(posedge M_AXI_ACLK) begin
    if (start) begin
      cmd_rnw   <= bus.REQ_RNW[arb_idx];
      cmd_addr  <= bus.REQ_ADDR[int'(arb_idx) * AW +: AW];
      cmd_wdata <= bus.REQ_WDATA[int'(arb_idx) * DW +: DW];
    end
  end

  always_comb begin
    mosi = '0;
    if (state == ST_ISSUE || state == ST_WAIT) begin
      if (cmd_rnw) begin
        mosi[MOSI_RADDR_LO +: AW] = cmd_addr;
      end else begin
        mosi[AW-1:0]              = cmd_addr;
        mosi[MOSI_WDATA_LO +: DW] = cmd_wdata;
      end
      if (state == ST_ISSUE) begin
        mosi[MOSI_WR_BIT] = ~cmd_rnw;
        mosi[MOSI_RD_BIT] = cmd_rnw;
      end
    end
  end

  assign bus.AMCI_MOSI = mosi;
  assign bus.REQ_GRANT = grant_q;
  assign bus.REQ_DONE  = done_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.RSP_RESP  = rsp_resp_q;

endmodule
